// File: rtl/conv_window.sv
// Sliding three-column window generator (prev, centre, next) with valid/ready on both sides.
// Define CONV_WINDOW_ZERO_PAD_EN for "same" zero padding; otherwise "valid" windows only.
module conv_window #(
   parameter int BW         = 8,
   parameter int FRAME_LEN  = 50,
   parameter int COLUMN_LEN = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [COLUMN_LEN*BW-1:0] data_i,
   input  logic                     valid_i,
   input  logic                     last_i,
   output logic                     ready_o,
   output logic [COLUMN_LEN*BW-1:0] data0_o,
   output logic [COLUMN_LEN*BW-1:0] data1_o,
   output logic [COLUMN_LEN*BW-1:0] data2_o,
   output logic                     valid_o,
   output logic                     last_o,
   input  logic                     ready_i,
   output logic                     err_o
);

   localparam int DW = COLUMN_LEN * BW;
   localparam int CW = $clog2(FRAME_LEN + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(FRAME_LEN - 1);

   typedef enum logic [1:0] {EMPTY, ONE, RUN, FLUSH} state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   prev_q, prev_d;
   logic [DW-1:0]   cur_q, cur_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   w0_q, w1_q, w2_q;
   logic [DW-1:0]   w0_d, w1_d, w2_d;
   logic            wlast_q, wlast_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;
   logic            load;
   logic            short_end;
   logic            slot_free;
   logic            accept;
   logic            xfer;

   assign slot_free = !valid_q || ready_i;
   assign ready_o   = (state_q != FLUSH) && slot_free;
   assign accept    = valid_i && ready_o;
   assign xfer      = valid_q && ready_i;

   always_comb begin
      state_d   = state_q;
      prev_d    = prev_q;
      cur_d     = cur_q;
      load      = 1'b0;
      w0_d      = prev_q;
      w1_d      = cur_q;
      w2_d      = data_i;
      wlast_d   = 1'b0;
      short_end = 1'b0;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               cur_d = data_i;
`ifdef CONV_WINDOW_ZERO_PAD_EN
               prev_d  = '0;
               state_d = last_i ? FLUSH : RUN;
`else
               short_end = last_i;
               state_d   = last_i ? EMPTY : ONE;
`endif
            end
         end
         ONE: begin
`ifdef CONV_WINDOW_ZERO_PAD_EN
            state_d = EMPTY;
`else
            if (accept) begin
               prev_d    = cur_q;
               cur_d     = data_i;
               short_end = last_i;
               state_d   = last_i ? EMPTY : RUN;
            end
`endif
         end
         RUN: begin
            if (accept) begin
               load   = 1'b1;
               prev_d = cur_q;
               cur_d  = data_i;
`ifdef CONV_WINDOW_ZERO_PAD_EN
               state_d = last_i ? FLUSH : RUN;
`else
               wlast_d = last_i;
               state_d = last_i ? EMPTY : RUN;
`endif
            end
         end
         FLUSH: begin
            // Trailing pad window waits for the output slot, not for input.
            if (slot_free) begin
               load    = 1'b1;
               w2_d    = '0;
               wlast_d = 1'b1;
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (accept) begin
         if (last_i)
            cnt_d = '0;
         else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + CW'(1);
      end
      err_d = err_q
            | (accept &&  last_i && (cnt_q != CNT_MAX))
            | (accept && !last_i && (cnt_q == CNT_MAX))
            | short_end;
      valid_d = load ? 1'b1 : (xfer ? 1'b0 : valid_q);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= EMPTY;
         prev_q  <= '0;
         cur_q   <= '0;
         cnt_q   <= '0;
         w0_q    <= '0;
         w1_q    <= '0;
         w2_q    <= '0;
         wlast_q <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         cur_q   <= cur_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         if (load) begin
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            wlast_q <= wlast_d;
         end
      end
   end

   assign data0_o = w0_q;
   assign data1_o = w1_q;
   assign data2_o = w2_q;
   assign last_o  = wlast_q;
   assign valid_o = valid_q;
   assign err_o   = err_q;

endmodule

// File: tb/tb_conv_window.sv
// Self-checking bench for conv_window: directed frames plus randomized traffic against a frame-level model.
module tb_conv_window;

   localparam int BW = 8;
   localparam int FL = 4;
   localparam int CL = 2;
   localparam int DW = CL * BW;
`ifdef CONV_WINDOW_ZERO_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   typedef struct packed {
      logic          last;
      logic [DW-1:0] c0;
      logic [DW-1:0] c1;
      logic [DW-1:0] c2;
   } win_t;

   logic          clk = 1'b0;
   logic          rst_i;
   logic [DW-1:0] data_i;
   logic          valid_i;
   logic          last_i;
   logic          ready_o;
   logic [DW-1:0] data0_o, data1_o, data2_o;
   logic          valid_o;
   logic          last_o;
   logic          ready_i;
   logic          err_o;

   conv_window #(.BW(BW), .FRAME_LEN(FL), .COLUMN_LEN(CL)) dut (
      .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
      .ready_o(ready_o), .data0_o(data0_o), .data1_o(data1_o), .data2_o(data2_o),
      .valid_o(valid_o), .last_o(last_o), .ready_i(ready_i), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int            n_cmp = 0;
   int            n_bad = 0;
   int            ready_mode = 0;
   int            lowcnt = 0;
   win_t          expq[$];
   win_t          logq[$];
   win_t          mlog[$];
   logic [DW-1:0] fr[$];
   logic          err_m = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] mk(input int v);
      logic [BW-1:0] b;
      b = v[BW-1:0];
      return {CL{b}};
   endfunction

   function automatic void push_w(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic [DW-1:0] c, input logic l);
      win_t w;
      w = {l, a, b, c};
      expq.push_back(w);
      mlog.push_back(w);
   endfunction

   // Frame-level model: windows are a function of the columns seen so far in the frame.
   function automatic void model_accept(input logic [DW-1:0] d, input logic l);
      int            n;
      logic [DW-1:0] z;
      z = '0;
      fr.push_back(d);
      n = fr.size();
      if (PAD) begin
         if (n >= 2) push_w((n >= 3) ? fr[n-3] : z, fr[n-2], fr[n-1], 1'b0);
         if (l)      push_w((n >= 2) ? fr[n-2] : z, fr[n-1], z, 1'b1);
      end else if (n >= 3) begin
         push_w(fr[n-3], fr[n-2], fr[n-1], l);
      end
      if (l) err_m = err_m | (n != FL);
      else   err_m = err_m | (n >= FL);
      if (l) fr.delete();
   endfunction

   always @(negedge clk) begin
      win_t o;
      o = {last_o, data0_o, data1_o, data2_o};
      if (rst_i) begin
         chk("rst_valid", 64'(valid_o), 64'(0));
         chk("rst_err", 64'(err_o), 64'(0));
         chk("rst_last", 64'(last_o), 64'(0));
         chk("rst_data", 64'({data0_o, data1_o, data2_o}), 64'(0));
         expq.delete();
         fr.delete();
         err_m = 1'b0;
      end else begin
         chk("err", 64'(err_o), 64'(err_m));
         if (!ready_o) lowcnt++;
         if (valid_o && !ready_i) chk("ready_full", 64'(ready_o), 64'(0));
         if (!PAD) chk("ready_rule", 64'(ready_o), 64'(!valid_o || ready_i));
         if (valid_o) begin
            if (expq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL window: got unexpected 0x%0h expected none at %0t", o, $time);
            end else begin
               chk("window", 64'(o), 64'(expq[0]));
            end
            if (ready_i) begin
               logq.push_back(o);
               if (expq.size() > 0) void'(expq.pop_front());
            end
         end
         if (valid_i && ready_o) model_accept(data_i, last_i);
      end
   end

   initial begin
      ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       ready_i = 1'b1;
            1:       ready_i = ($urandom_range(0, 3) != 0);
            default: ready_i = 1'b0;
         endcase
      end
   end

   task automatic send(input logic [DW-1:0] d, input logic l);
      int t;
      t = 0;
      valid_i = 1'b1;
      data_i  = d;
      last_i  = l;
      forever begin
         @(negedge clk);
         if (ready_o) break;
         t++;
         if (t > 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      last_i  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic frame(input int first, input int len);
      for (int k = 0; k < len; k++) send(mk(first + k), k == len - 1);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_i = 1'b0;
   endtask

   task automatic check_log(input string nm, input int ex[$]);
      int nw;
      nw = ex.size() / 4;
      chk({nm, "_count"}, 64'(logq.size()), 64'(nw));
      chk({nm, "_mcount"}, 64'(mlog.size()), 64'(nw));
      for (int i = 0; i < nw; i++) begin
         win_t e;
         e = {ex[4*i+3] != 0, mk(ex[4*i]), mk(ex[4*i+1]), mk(ex[4*i+2])};
         if (i < logq.size()) chk($sformatf("%s_w%0d", nm, i), 64'(logq[i]), 64'(e));
         if (i < mlog.size()) chk($sformatf("%s_m%0d", nm, i), 64'(mlog[i]), 64'(e));
      end
      logq.delete();
      mlog.delete();
   endtask

   initial begin
      int            ex[$];
      logic [DW-1:0] rd;
      int            len;
      int            t;
      valid_i = 1'b0;
      data_i  = '0;
      last_i  = 1'b0;
      rst_i   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_i = 1'b0;
      idle(1);

      if (PAD) ex = '{0,1,2,0, 1,2,3,0, 2,3,4,0, 3,4,0,1};
      else     ex = '{1,2,3,0, 2,3,4,1};

      // single frame, no backpressure
      logq.delete(); mlog.delete(); lowcnt = 0;
      frame(1, 4);
      idle(6);
      check_log("frame1", ex);
      chk("frame1_bubble", 64'(lowcnt), PAD ? 64'(1) : 64'(0));
      chk("frame1_err", 64'(err_o), 64'(0));

      // backpressure: stall right after the first window loads
      fork
         frame(1, 4);
         begin
            t = 0;
            do begin @(negedge clk); t++; end
            while (!(valid_i && ready_o && data_i == mk(PAD ? 2 : 3)) && t < 100);
            ready_mode = 2;
            do begin @(negedge clk); t++; end while (!valid_o && t < 200);
            chk("stall_timeout", 64'(t < 200), 64'(1));
            for (int i = 0; i < 5; i++) begin
               chk("stall_data", 64'({last_o, data0_o, data1_o, data2_o}),
                   PAD ? 64'({1'b0, mk(0), mk(1), mk(2)}) : 64'({1'b0, mk(1), mk(2), mk(3)}));
               chk("stall_ready", 64'(ready_o), 64'(0));
               if (i < 4) @(negedge clk);
            end
            ready_mode = 0;
         end
      join
      idle(8);
      check_log("stall", ex);

      // two frames back to back
      lowcnt = 0;
      frame(1, 4);
      frame(5, 4);
      idle(6);
      if (PAD) ex = '{0,1,2,0, 1,2,3,0, 2,3,4,0, 3,4,0,1, 0,5,6,0, 5,6,7,0, 6,7,8,0, 7,8,0,1};
      else     ex = '{1,2,3,0, 2,3,4,1, 5,6,7,0, 6,7,8,1};
      check_log("b2b", ex);
      chk("b2b_bubble", 64'(lowcnt), PAD ? 64'(2) : 64'(0));

      // short frame sets sticky error
      frame(1, 2);
      idle(4);
      if (PAD) ex = '{0,1,2,0, 1,2,0,1};
      else     ex = '{};
      check_log("short", ex);
      chk("short_err", 64'(err_o), 64'(1));
      frame(1, 4);
      idle(6);
      chk("sticky_err", 64'(err_o), 64'(1));
      logq.delete(); mlog.delete();

      // reset mid-frame, then a clean frame
      send(mk(1), 1'b0);
      send(mk(2), 1'b0);
      do_reset();
      logq.delete(); mlog.delete();
      frame(1, 4);
      idle(6);
      if (PAD) ex = '{0,1,2,0, 1,2,3,0, 2,3,4,0, 3,4,0,1};
      else     ex = '{1,2,3,0, 2,3,4,1};
      check_log("post_rst", ex);
      chk("post_rst_err", 64'(err_o), 64'(0));

      // randomized traffic with random backpressure and occasional bad frame lengths
      ready_mode = 1;
      for (int f = 0; f < 40; f++) begin
         len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : FL;
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 2) == 0) idle(1);
            rd = DW'($urandom);
            send(rd, k == len - 1);
         end
      end
      ready_mode = 0;
      t = 0;
      while ((expq.size() != 0 || valid_o) && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("drain_pending", 64'(expq.size()), 64'(0));
      chk("drain_valid", 64'(valid_o), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/conv_window.md
# conv_window

Sliding three-column window generator sitting between the column serial-in/parallel-out stage and the width-3 convolution MAC array. It accepts one feature column per handshake and emits, for every column position in a frame, a three-column window: previous, centre and next column. It zero-pads at frame edges so the convolution output length equals the input frame length. The block buffers two columns internally and provides full valid/ready backpressure on both sides.

## Interface
- BW, 8, bits per signed element
- FRAME_LEN, 50, columns per frame (last_i expected on column FRAME_LEN-1)
- COLUMN_LEN, 8, elements per column
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- data_i  in  COLUMN_LEN*BW  signed input column
- valid_i  in  1  input column valid
- last_i  in  1  input column is the final column of its frame
- ready_o  out  1  block can accept a column this cycle
- data0_o  out  COLUMN_LEN*BW  window column k-1 (oldest)
- data1_o  out  COLUMN_LEN*BW  window column k (centre)
- data2_o  out  COLUMN_LEN*BW  window column k+1 (newest)
- valid_o  out  1  window valid
- last_o  out  1  window is the final window of its frame
- ready_i  in  1  downstream accepts window
- err_o  out  1  sticky frame-length error

## Operation
- Accept: valid_i && ready_o. Output transfer: valid_o && ready_i.
- Output slot free: !valid_o || ready_i. ready_o = (state != FLUSH) && slot free.
- Registers: prev, cur (columns), column counter cnt of width $clog2(FRAME_LEN+1), and the output window registers.
- States:
  - EMPTY: no column held. On accept: cur<=data_i, prev<=0. Next state is FLUSH if last_i, else RUN.
  - RUN: on accept: load window {prev,cur,data_i} with last_o=0; prev<=cur; cur<=data_i. Next state is FLUSH if last_i.
  - FLUSH: ready_o=0. When the slot is free: load window {prev,cur,0} with last_o=1, then go to EMPTY.
  - ONE: used only without padding; see Configuration.
- A transfer with no new load clears valid_o.
- cnt increments on each accept and clears to 0 on an accept with last_i.
- err_o is set and held until reset in either case:
  - accept with last_i while cnt != FRAME_LEN-1;
  - accept with !last_i while cnt == FRAME_LEN-1. In this case cnt saturates and the frame continues until last_i.
- Data passes through bit-exact; no arithmetic. Zero pad = all-zero column.

## Timing
- Reset values: valid_o=0, last_o=0, data0_o/data1_o/data2_o=0, err_o=0, state=EMPTY, cnt=0.
- Reset asserted mid-frame discards all held columns and windows immediately.
- Window for centre k is registered: valid_o rises the cycle after column k+1 is accepted.
- Final (padded) window appears at the earliest 2 cycles after last column accept, and only once the preceding window has transferred or is transferring.
- ready_o depends combinationally on ready_i. No combinational path exists from valid_i to valid_o.
- Sustained throughput: one column per cycle while ready_i=1, plus one bubble per frame (FLUSH).
- Back-to-back frames: a column presented during FLUSH is stalled. It is accepted in EMPTY the cycle after the flush window loads.
- Output data and last_o hold stable while valid_o && !ready_i.

## Configuration
- CONV_WINDOW_ZERO_PAD_EN defined (padded mode):
  - "same" padding, behaviour as above; FRAME_LEN windows per frame.
- CONV_WINDOW_ZERO_PAD_EN undefined ("valid" mode):
  - No padding; FRAME_LEN-2 windows per frame.
  - EMPTY accept goes to ONE (cur<=data_i). ONE accept goes to RUN (prev<=cur, cur<=data_i) with no emit.
  - RUN accept with last_i emits {prev,cur,data_i} with last_o=1 and returns to EMPTY.
  - FLUSH is never entered.
  - A frame ending in EMPTY or ONE emits nothing, returns to EMPTY, and sets err_o.

## Test plan
FRAME_LEN=4, COLUMN_LEN=2, BW=8; column k has both elements = k+1.
- Padded frame, ready_i=1, columns 1,2,3,4 back-to-back (last on 4):
  - windows {0,1,2},{1,2,3},{2,3,4},{3,4,0};
  - last_o only on the fourth window; err_o=0; ready_o low exactly one cycle.
- Backpressure:
  - ready_i=0 for 5 cycles after the first window: window {0,1,2} held stable, ready_o=0 while the slot is full;
  - after release, same four windows, no loss or duplication.
- Two frames back-to-back (columns 1-4 then 5-8): eight windows; second frame starts {0,5,6}; last_o on {3,4,0} and {7,8,0}.
- Short frame (last on column 2, values 1,2): windows {0,1,2},{1,2,0}; err_o=1 and stays 1 through a following correct frame.
- Reset asserted mid-frame after 2 columns:
  - valid_o=0 and err_o=0 during reset;
  - a next full frame produces the exact padded sequence.
- CONV_WINDOW_ZERO_PAD_EN undefined, columns 1-4: windows {1,2,3},{2,3,4}, last_o on the second; a 2-column frame gives no window and err_o=1.
